// File: rtl/bldc_encoder_capture.sv
// Multi-channel quadrature encoder front end: per-channel 2-FF sync, glitch
// filter, wrapping position counter, saturating per-period delta and sticky
// illegal-transition flags. All channels run independently in parallel.
module bldc_encoder_capture #(
  parameter int NUM_CH        = 5,
  parameter int COUNTER_WIDTH = 15,
  parameter int DELTA_WIDTH   = 12,
  parameter int FILTER_LEN    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*NUM_CH-1:0]             enc,
  input  logic                            latch,
  input  logic                            err_clr,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] count,
  output logic [NUM_CH*DELTA_WIDTH-1:0]   delta,
  output logic                            delta_valid,
  output logic [NUM_CH-1:0]               err
);
  localparam int CW = COUNTER_WIDTH;
  localparam int DW = DELTA_WIDTH;
  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [RW-1:0] RUN_DONE = RW'(FILTER_LEN);
  localparam logic [DW-1:0] ACC_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] ACC_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic [2*NUM_CH-1:0]  r_s1, r_s2, r_f, r_cand;
  logic [NUM_CH*RW-1:0] r_run;
  logic [NUM_CH*DW-1:0] r_acc, r_delta;
  logic [NUM_CH*CW-1:0] r_count;
  logic                 r_dv;
  logic [NUM_CH-1:0]    r_err;

  logic [NUM_CH-1:0]    w_accept, w_up, w_dn, w_ill;
  logic [2*NUM_CH-1:0]  w_diff;
  logic [NUM_CH*DW-1:0] w_acc_nx;

  // Position of a {B,A} code along the Gray cycle 00,01,11,10
  function automatic logic [1:0] gray_pos(input logic [1:0] v);
    return {v[1], v[1] ^ v[0]};
  endfunction

  // Decode the transition being accepted this cycle and the saturated accumulator sum
  always_comb begin
    w_accept = '0;
    w_up     = '0;
    w_dn     = '0;
    w_ill    = '0;
    w_diff   = '0;
    w_acc_nx = r_acc;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_accept[i] = (r_s2[2*i +: 2] != r_f[2*i +: 2]) &&
                    (r_s2[2*i +: 2] == r_cand[2*i +: 2]) &&
                    (r_run[RW*i +: RW] == RUN_DONE);
      w_diff[2*i +: 2] = gray_pos(r_s2[2*i +: 2]) - gray_pos(r_f[2*i +: 2]);
      w_up[i]  = w_accept[i] && (w_diff[2*i +: 2] == 2'd1);
      w_dn[i]  = w_accept[i] && (w_diff[2*i +: 2] == 2'd3);
      w_ill[i] = w_accept[i] && (w_diff[2*i +: 2] == 2'd2);
      if (w_up[i] && (r_acc[DW*i +: DW] != ACC_MAX))
        w_acc_nx[DW*i +: DW] = r_acc[DW*i +: DW] + DW'(1);
      else if (w_dn[i] && (r_acc[DW*i +: DW] != ACC_MIN))
        w_acc_nx[DW*i +: DW] = r_acc[DW*i +: DW] - DW'(1);
    end
  end

  // Sync, filter run, count, accumulate/latch and sticky errors; reset reloads sync/filter from enc
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= enc;
      r_s2    <= enc;
      r_f     <= enc;
      r_cand  <= enc;
      r_run   <= '0;
      r_acc   <= '0;
      r_delta <= '0;
      r_count <= '0;
      r_dv    <= 1'b0;
      r_err   <= '0;
    end else begin
      r_s1 <= enc;
      r_s2 <= r_s1;
      r_dv <= latch;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // run counts edges the synced value has differed from f while staying constant
        if (r_s2[2*i +: 2] == r_f[2*i +: 2]) begin
          r_run[RW*i +: RW] <= '0;
        end else if (r_s2[2*i +: 2] != r_cand[2*i +: 2]) begin
          r_cand[2*i +: 2]  <= r_s2[2*i +: 2];
          r_run[RW*i +: RW] <= RW'(1);
        end else if (w_accept[i]) begin
          r_f[2*i +: 2]     <= r_s2[2*i +: 2];
          r_run[RW*i +: RW] <= '0;
        end else begin
          r_run[RW*i +: RW] <= r_run[RW*i +: RW] + RW'(1);
        end

        if (w_up[i])
          r_count[CW*i +: CW] <= r_count[CW*i +: CW] + CW'(1);
        else if (w_dn[i])
          r_count[CW*i +: CW] <= r_count[CW*i +: CW] - CW'(1);

        // a step on the latch edge is folded into the period being closed
        if (latch) begin
          r_delta[DW*i +: DW] <= w_acc_nx[DW*i +: DW];
          r_acc[DW*i +: DW]   <= '0;
        end else begin
          r_acc[DW*i +: DW]   <= w_acc_nx[DW*i +: DW];
        end

        if (w_ill[i])
          r_err[i] <= 1'b1;
        else if (err_clr)
          r_err[i] <= 1'b0;
      end
    end
  end

  assign count       = r_count;
  assign delta       = r_delta;
  assign delta_valid = r_dv;
  assign err         = r_err;

endmodule

// File: tb/tb_bldc_encoder_capture.sv
// Self-checking bench for bldc_encoder_capture: directed scenarios plus a
// randomized run, all checked against a per-channel position model.
module tb_bldc_encoder_capture;
  localparam int NUM_CH = 5;
  localparam int CW     = 15;
  localparam int DW     = 12;
  localparam int FL     = 4;
  localparam int DMAX   = (1 << (DW - 1)) - 1;
  localparam int DMIN   = -(1 << (DW - 1));

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [2*NUM_CH-1:0]    enc = '0;
  logic                   latch = 1'b0;
  logic                   err_clr = 1'b0;
  logic [NUM_CH*CW-1:0]   count;
  logic [NUM_CH*DW-1:0]   delta;
  logic                   delta_valid;
  logic [NUM_CH-1:0]      err;

  bldc_encoder_capture #(
    .NUM_CH        (NUM_CH),
    .COUNTER_WIDTH (CW),
    .DELTA_WIDTH   (DW),
    .FILTER_LEN    (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enc         (enc),
    .latch       (latch),
    .err_clr     (err_clr),
    .count       (count),
    .delta       (delta),
    .delta_valid (delta_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: Gray-cycle position, wrapped count, saturated accumulator, last delta, sticky error
  int m_pos   [NUM_CH];
  int m_cnt   [NUM_CH];
  int m_acc   [NUM_CH];
  int m_delta [NUM_CH];
  bit m_err   [NUM_CH];
  int m_dir   [NUM_CH];

  function automatic logic [1:0] code_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int pos_of(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_add(input int a, input int d);
    int s;
    s = a + d;
    if (s > DMAX) return DMAX;
    if (s < DMIN) return DMIN;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_enc();
    for (int ch = 0; ch < NUM_CH; ch++) enc[2*ch +: 2] = code_of(m_pos[ch]);
  endtask

  task automatic model_step(input int ch, input int d);
    if (d == 2) begin
      m_err[ch] = 1'b1;
    end else if (d != 0) begin
      m_cnt[ch] = (m_cnt[ch] + d) & ((1 << CW) - 1);
      m_acc[ch] = sat_add(m_acc[ch], d);
    end
    m_pos[ch] = (m_pos[ch] + d) & 3;
  endtask

  task automatic do_reset();
    reset = 1'b1; latch = 1'b0; err_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_pos[ch] = pos_of(enc[2*ch +: 2]);
      m_cnt[ch] = 0; m_acc[ch] = 0; m_delta[ch] = 0; m_err[ch] = 1'b0; m_dir[ch] = 0;
    end
  endtask

  // Apply m_dir on every channel at once and hold for 'hold' cycles
  task automatic step_all(input int hold);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      model_step(ch, m_dir[ch]);
      m_dir[ch] = 0;
    end
    drive_enc();
    tick(hold);
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_delta[ch] = m_acc[ch];
      m_acc[ch]   = 0;
    end
  endtask

  task automatic test_reset();
    enc = 10'($urandom);
    do_reset();
    n_tests++;
    if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %h, expected 0", count); end
    n_tests++;
    if (delta !== '0) begin n_fail++; $display("FAIL reset_delta: got %h, expected 0", delta); end
    n_tests++;
    if (err !== '0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
    n_tests++;
    if (delta_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b, expected 0", delta_valid); end
    tick(12);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_tests++;
      if (count[CW*ch +: CW] !== CW'(m_cnt[ch])) begin
        n_fail++; $display("FAIL release_nocount ch%0d: got %0d, expected %0d", ch, count[CW*ch +: CW], m_cnt[ch]);
      end
    end
  endtask

  task automatic test_forward();
    enc = '0;
    do_reset();
    for (int k = 0; k < 4; k++) begin m_dir[0] = 1; step_all(10); end
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL forward4 count0: got %0d, expected %0d", count[0 +: CW], m_cnt[0]);
    end
    n_tests++;
    if (err !== '0) begin n_fail++; $display("FAIL forward4 err: got %b, expected 0", err); end
  endtask

  task automatic test_wrap();
    do_reset();
    m_dir[0] = -1; step_all(10);
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL wrap_down count0: got %h, expected %h", count[0 +: CW], m_cnt[0]);
    end
    m_dir[0] = 1; step_all(10);
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL wrap_up count0: got %h, expected %h", count[0 +: CW], m_cnt[0]);
    end
  endtask

  task automatic test_glitch_latency();
    int old;
    enc[1:0] = code_of(m_pos[0] + 1);
    tick(2);
    enc[1:0] = code_of(m_pos[0]);
    tick(12);
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL glitch count0: got %0d, expected %0d", count[0 +: CW], m_cnt[0]);
    end
    old = m_cnt[0];
    model_step(0, 1);
    drive_enc();
    tick(FL + 2);
    n_tests++;
    if (count[0 +: CW] !== CW'(old)) begin
      n_fail++; $display("FAIL latency_early count0: got %0d, expected %0d", count[0 +: CW], old);
    end
    tick(1);
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL latency_due count0: got %0d, expected %0d", count[0 +: CW], m_cnt[0]);
    end
    tick(4);
  endtask

  task automatic test_delta();
    logic signed [DW-1:0] d;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      m_dir[1] = 1;
      if (k < 7) m_dir[2] = -1;
      step_all(10);
    end
    for (int pass = 0; pass < 2; pass++) begin
      pulse_latch();
      n_tests++;
      if (delta_valid !== 1'b1) begin n_fail++; $display("FAIL delta_dv pass%0d: got %b, expected 1", pass, delta_valid); end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        d = delta[DW*ch +: DW];
        n_tests++;
        if (int'(d) != m_delta[ch]) begin
          n_fail++; $display("FAIL delta pass%0d ch%0d: got %0d, expected %0d", pass, ch, d, m_delta[ch]);
        end
      end
      tick(1);
      n_tests++;
      if (delta_valid !== 1'b0) begin n_fail++; $display("FAIL delta_dv_end pass%0d: got %b, expected 0", pass, delta_valid); end
      tick(3);
    end
  endtask

  task automatic test_saturate();
    logic signed [DW-1:0] d;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      m_dir[0] = 1;
      if (k < 2100) m_dir[4] = -1;
      step_all(7);
    end
    pulse_latch();
    for (int ch = 0; ch < NUM_CH; ch += 4) begin
      d = delta[DW*ch +: DW];
      n_tests++;
      if (int'(d) != m_delta[ch]) begin
        n_fail++; $display("FAIL saturate delta ch%0d: got %0d, expected %0d", ch, d, m_delta[ch]);
      end
      n_tests++;
      if (count[CW*ch +: CW] !== CW'(m_cnt[ch])) begin
        n_fail++; $display("FAIL saturate count ch%0d: got %0d, expected %0d", ch, count[CW*ch +: CW], m_cnt[ch]);
      end
    end
    tick(2);
  endtask

  task automatic test_illegal();
    m_dir[3] = 2; step_all(10);
    n_tests++;
    if (err[3] !== m_err[3]) begin n_fail++; $display("FAIL illegal err3: got %b, expected %b", err[3], m_err[3]); end
    n_tests++;
    if (count[CW*3 +: CW] !== CW'(m_cnt[3])) begin
      n_fail++; $display("FAIL illegal count3: got %0d, expected %0d", count[CW*3 +: CW], m_cnt[3]);
    end
    // second illegal lands on the same edge as err_clr: set must win
    model_step(3, 2);
    drive_enc();
    tick(FL + 2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) if (ch != 3) m_err[ch] = 1'b0;
    n_tests++;
    if (err[3] !== m_err[3]) begin n_fail++; $display("FAIL illegal_vs_clr err3: got %b, expected %b", err[3], m_err[3]); end
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) m_err[ch] = 1'b0;
    n_tests++;
    if (err !== '0) begin n_fail++; $display("FAIL err_clr: got %b, expected 0", err); end
  endtask

  task automatic test_latch_coincide();
    logic signed [DW-1:0] d;
    pulse_latch(); tick(2);
    // step accepted on the latch edge belongs to the closing period
    model_step(0, 1); drive_enc();
    tick(FL + 2);
    pulse_latch();
    d = delta[0 +: DW];
    n_tests++;
    if (int'(d) != m_delta[0]) begin n_fail++; $display("FAIL coincide delta0: got %0d, expected %0d", d, m_delta[0]); end
    tick(5); pulse_latch();
    d = delta[0 +: DW];
    n_tests++;
    if (int'(d) != m_delta[0]) begin n_fail++; $display("FAIL coincide_next delta0: got %0d, expected %0d", d, m_delta[0]); end
    // latch one edge before the step: step goes to the next period
    drive_enc();
    enc[1:0] = code_of(m_pos[0] + 1);
    tick(FL + 1);
    pulse_latch();
    model_step(0, 1);
    d = delta[0 +: DW];
    n_tests++;
    if (int'(d) != m_delta[0]) begin n_fail++; $display("FAIL early_latch delta0: got %0d, expected %0d", d, m_delta[0]); end
    tick(5); pulse_latch();
    d = delta[0 +: DW];
    n_tests++;
    if (int'(d) != m_delta[0]) begin n_fail++; $display("FAIL early_latch_next delta0: got %0d, expected %0d", d, m_delta[0]); end
    tick(2);
  endtask

  task automatic test_latch_held();
    logic signed [DW-1:0] d;
    int exp_d [3];
    exp_d[0] = 0; exp_d[1] = 1; exp_d[2] = 0;
    enc[1:0] = code_of(m_pos[0] + 1);
    tick(FL + 1);
    latch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (k == 1) model_step(0, 1);
      d = delta[0 +: DW];
      n_tests++;
      if (delta_valid !== 1'b1 || int'(d) != exp_d[k]) begin
        n_fail++; $display("FAIL latch_held cyc%0d: got dv=%b delta0=%0d, expected dv=1 delta0=%0d", k, delta_valid, d, exp_d[k]);
      end
    end
    latch = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) m_acc[ch] = 0;
    tick(1);
    n_tests++;
    if (delta_valid !== 1'b0) begin n_fail++; $display("FAIL latch_held_end dv: got %b, expected 0", delta_valid); end
    n_tests++;
    if (count[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL latch_held count0: got %0d, expected %0d", count[0 +: CW], m_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] d;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_dir[ch] = 1;
      step_all(10);
    end
    // reset during a latch, a pending filter run and with enc moving
    enc = 10'($urandom);
    latch = 1'b1;
    tick(2);
    do_reset();
    tick(10);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_tests++;
      if (count[CW*ch +: CW] !== CW'(m_cnt[ch])) begin
        n_fail++; $display("FAIL reset_mid count ch%0d: got %0d, expected %0d", ch, count[CW*ch +: CW], m_cnt[ch]);
      end
    end
    for (int k = 0; k < 2; k++) begin m_dir[0] = 1; m_dir[1] = -1; step_all(10); end
    pulse_latch();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      d = delta[DW*ch +: DW];
      n_tests++;
      if (int'(d) != m_delta[ch]) begin
        n_fail++; $display("FAIL reset_mid delta ch%0d: got %0d, expected %0d", ch, d, m_delta[ch]);
      end
    end
    tick(2);
  endtask

  task automatic test_random();
    logic signed [DW-1:0] d;
    int r, c;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, NUM_CH - 1);
        enc[2*c +: 2] = code_of(m_pos[c] + 1);
        tick($urandom_range(1, FL - 1));
        enc[2*c +: 2] = code_of(m_pos[c]);
        tick(2);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r = $urandom_range(0, 15);
        if (r == 0)      m_dir[ch] = 2;
        else if (r <= 5) m_dir[ch] = 1;
        else if (r <= 10) m_dir[ch] = -1;
        else             m_dir[ch] = 0;
      end
      step_all($urandom_range(8, 12));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        n_tests++;
        if (count[CW*ch +: CW] !== CW'(m_cnt[ch]) || err[ch] !== m_err[ch]) begin
          n_fail++;
          $display("FAIL random seg%0d ch%0d: got count=%0d err=%b, expected count=%0d err=%b",
                   seg, ch, count[CW*ch +: CW], err[ch], m_cnt[ch], m_err[ch]);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_latch();
        n_tests++;
        if (delta_valid !== 1'b1) begin n_fail++; $display("FAIL random dv seg%0d: got %b, expected 1", seg, delta_valid); end
        for (int ch = 0; ch < NUM_CH; ch++) begin
          d = delta[DW*ch +: DW];
          n_tests++;
          if (int'(d) != m_delta[ch]) begin
            n_fail++; $display("FAIL random delta seg%0d ch%0d: got %0d, expected %0d", seg, ch, d, m_delta[ch]);
          end
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) m_err[ch] = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    tick(1);
    test_reset();
    test_forward();
    test_wrap();
    test_glitch_latency();
    test_delta();
    test_saturate();
    test_illegal();
    test_latch_coincide();
    test_latch_held();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
